// File: rtl/uart_parity_engine_pkg.sv
// uart_parity_engine_pkg
//   Shared types and helpers for the UART parity engine.
//   - par_mode_e  : parity mode encodings (even / odd / mark / space)
//   - state_e     : frame FSM states
//   - frame_cfg_t : per-frame configuration latched on START
//   - masked_xor  : XOR of the low 'len' bits of a word (parallel LD path)
//   - exp_parity  : parity bit for a given mode and data XOR
package uart_parity_engine_pkg;

    localparam int MAX_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    typedef struct packed {
        par_mode_e mode;
        logic      chk;
    } frame_cfg_t;

    // XOR of data[len-1:0]; bits at or above len are masked off.
    function automatic logic masked_xor(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input int                        len);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < len) r = r ^ data[i];
        end
        return r;
    endfunction

    // Mark/space ignore the data entirely.
    function automatic logic exp_parity(input par_mode_e mode, input logic acc);
        logic r;
        case (mode)
            PAR_EVEN:  r = acc;
            PAR_ODD:   r = ~acc;
            PAR_MARK:  r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_parity_engine_if.sv
// uart_parity_engine_if
//   Control/data bundle between a UART serializer/deserializer (master) and
//   the parity engine (slave).
//   master -> slave : PAR_EN, PAR_MODE, DATA_LEN, CHK_EN, START, BIT_VALID,
//                     BIT_IN, LD, P_DATA, CLR_CNT
//   slave -> master : BUSY, par_bit, par_valid, par_err, err_cnt
interface uart_parity_engine_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    localparam int LEN_W = $clog2(DATA_WIDTH + 1);

    logic                     PAR_EN;
    logic [1:0]               PAR_MODE;
    logic [LEN_W-1:0]         DATA_LEN;
    logic                     CHK_EN;
    logic                     START;
    logic                     BIT_VALID;
    logic                     BIT_IN;
    logic                     LD;
    logic [DATA_WIDTH-1:0]    P_DATA;
    logic                     CLR_CNT;
    logic                     BUSY;
    logic                     par_bit;
    logic                     par_valid;
    logic                     par_err;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    modport master (
        output PAR_EN, PAR_MODE, DATA_LEN, CHK_EN, START, BIT_VALID, BIT_IN,
               LD, P_DATA, CLR_CNT,
        input  BUSY, par_bit, par_valid, par_err, err_cnt
    );

    modport slave (
        input  PAR_EN, PAR_MODE, DATA_LEN, CHK_EN, START, BIT_VALID, BIT_IN,
               LD, P_DATA, CLR_CNT,
        output BUSY, par_bit, par_valid, par_err, err_cnt
    );

endinterface

// File: rtl/uart_parity_engine.sv
// uart_parity_engine
//   Registered parity generator/checker for the UART datapath. Serial frames
//   are accumulated one bit per BIT_VALID after START; a parallel word is
//   handled in one cycle on LD. In check mode the bit after the data is the
//   received parity and a mismatch pulses par_err and bumps a saturating
//   error counter.
//   Ports:
//     CLK  : system clock, rising edge
//     RST  : asynchronous active-low reset
//     bus  : uart_parity_engine_if.slave (config, strobes, results)
module uart_parity_engine
    import uart_parity_engine_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic CLK,
    input  logic RST,
    uart_parity_engine_if.slave bus
);

    localparam int LEN_W = $clog2(DATA_WIDTH + 1);

    state_e                   state_q, state_d;
    frame_cfg_t               cfg_q, cfg_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic                     acc_q, acc_d;
    logic                     par_bit_q, par_bit_d;
    logic                     par_valid_q, par_valid_d;
    logic                     par_err_q, par_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [MAX_DATA_WIDTH-1:0] pdata_ext;
    logic                      exp_bit;

    // Zero and over-range lengths both mean a full-width frame.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        if (l == '0 || l > LEN_W'(DATA_WIDTH)) return LEN_W'(DATA_WIDTH);
        return l;
    endfunction

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        par_bit_d   = par_bit_q;
        par_valid_d = 1'b0;
        par_err_d   = 1'b0;
        exp_bit     = 1'b0;
        pdata_ext   = '0;
        pdata_ext[DATA_WIDTH-1:0] = bus.P_DATA;

        if (!bus.PAR_EN) begin
            // Disabled: abandon any frame silently and hold par_bit low.
            state_d   = IDLE;
            cnt_d     = '0;
            par_bit_d = 1'b0;
        end else if (bus.START) begin
            // START wins over LD and swallows a coincident BIT_VALID.
            cfg_d.mode = par_mode_e'(bus.PAR_MODE);
            cfg_d.chk  = bus.CHK_EN;
            len_d      = eff_len(bus.DATA_LEN);
            cnt_d      = '0;
            acc_d      = 1'b0;
            state_d    = DATA;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.LD) begin
                        exp_bit     = exp_parity(par_mode_e'(bus.PAR_MODE),
                                          masked_xor(pdata_ext, int'(eff_len(bus.DATA_LEN))));
                        par_bit_d   = exp_bit;
                        par_valid_d = 1'b1;
                    end
                end
                DATA: begin
                    if (bus.BIT_VALID) begin
                        acc_d = acc_q ^ bus.BIT_IN;
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_d == len_q) begin
                            if (cfg_q.chk) begin
                                state_d = PAR;
                            end else begin
                                par_bit_d   = exp_parity(cfg_q.mode, acc_d);
                                par_valid_d = 1'b1;
                                state_d     = IDLE;
                            end
                        end
                    end
                end
                PAR: begin
                    if (bus.BIT_VALID) begin
                        exp_bit     = exp_parity(cfg_q.mode, acc_q);
                        par_bit_d   = exp_bit;
                        par_valid_d = 1'b1;
                        par_err_d   = (bus.BIT_IN != exp_bit);
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Counter moves on the same edge that exposes par_err; clear wins.
        err_cnt_d = err_cnt_q;
        if (bus.CLR_CNT)
            err_cnt_d = '0;
        else if (par_err_d && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            par_bit_q   <= 1'b0;
            par_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            par_bit_q   <= par_bit_d;
            par_valid_q <= par_valid_d;
            par_err_q   <= par_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.BUSY      = (state_q != IDLE);
    assign bus.par_bit   = par_bit_q;
    assign bus.par_valid = par_valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// tb_uart_parity_engine
//   Directed stimulus with hand-computed results pushed to a scoreboard; a
//   negedge monitor pops an entry on every par_valid and checks cycle,
//   par_bit, par_err and err_cnt.
module tb_uart_parity_engine;
    import uart_parity_engine_pkg::*;

    localparam int DW = 8;
    localparam int EW = 8;
    localparam int LW = $clog2(DW + 1);

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_parity_engine_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) bus();

    uart_parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic          pb;
        logic          pe;
        logic [EW-1:0] ec;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every par_valid must match the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b1) begin
            if (bus.par_valid === 1'b1) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_par_valid cyc=%0d par_bit=%b par_err=%b",
                             cyc, bus.par_bit, bus.par_err);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.cyc || bus.par_bit !== e.pb || bus.par_err !== e.pe ||
                        bus.err_cnt !== e.ec) begin
                        n_bad++;
                        $display("FAIL result got cyc=%0d pb=%b pe=%b ec=%0d want cyc=%0d pb=%b pe=%b ec=%0d",
                                 cyc, bus.par_bit, bus.par_err, bus.err_cnt,
                                 e.cyc, e.pb, e.pe, e.ec);
                    end
                end
            end else if (bus.par_err !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL par_err_without_valid cyc=%0d par_err=%b", cyc, bus.par_err);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called right after the edge that produces the result.
    task automatic push(input logic pb, input logic pe, input logic [EW-1:0] ec);
        exp_t e;
        e.pb = pb; e.pe = pe; e.ec = ec; e.cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [LW-1:0] l, input logic c);
        bus.START = 1'b1; bus.PAR_MODE = m; bus.DATA_LEN = l; bus.CHK_EN = c;
        tick();
        bus.START = 1'b0;
    endtask

    // Sends n bits LSB-first on back-to-back cycles.
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.BIT_VALID = 1'b1;
            bus.BIT_IN    = bits[i];
            tick();
        end
        bus.BIT_VALID = 1'b0;
        bus.BIT_IN    = 1'b0;
    endtask

    task automatic do_ld(input logic [1:0] m, input logic [LW-1:0] l, input logic [DW-1:0] d);
        bus.LD = 1'b1; bus.PAR_MODE = m; bus.DATA_LEN = l; bus.P_DATA = d;
        tick();
        bus.LD = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        bus.PAR_EN = 1'b1; bus.PAR_MODE = 2'b00; bus.DATA_LEN = '0; bus.CHK_EN = 1'b0;
        bus.START = 1'b0; bus.BIT_VALID = 1'b0; bus.BIT_IN = 1'b0; bus.LD = 1'b0;
        bus.P_DATA = '0; bus.CLR_CNT = 1'b0;
        tick(); tick();
        check("rst_busy",      32'(bus.BUSY),      32'd0);
        check("rst_par_bit",   32'(bus.par_bit),   32'd0);
        check("rst_par_valid", 32'(bus.par_valid), 32'd0);
        check("rst_par_err",   32'(bus.par_err),   32'd0);
        check("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        RST = 1'b1;
        tick();

        // TX even, 8 bits 1,0,1,1,0,0,0,0 -> three ones -> parity 1
        start_frame(PAR_EVEN, 4'd8, 1'b0);
        check("busy_after_start", 32'(bus.BUSY), 32'd1);
        send_bits(16'b0000_1101, 8);
        push(1'b1, 1'b0, 8'd0);
        check("busy_after_tx", 32'(bus.BUSY), 32'd0);

        // RX odd, 7 bits of 0x55 (four ones), received 0, expected 1 -> error
        start_frame(PAR_ODD, 4'd7, 1'b1);
        send_bits(16'h0055, 7);
        check("busy_in_par", 32'(bus.BUSY), 32'd1);
        send_bits(16'h0000, 1);
        push(1'b1, 1'b1, 8'd1);

        // LD even, len 5, 0xFF -> 0x1F -> parity 1
        do_ld(PAR_EVEN, 4'd5, 8'hFF);
        push(1'b1, 1'b0, 8'd1);
        // LD odd, len 0 -> full width, 0x01 -> odd parity 0
        do_ld(PAR_ODD, 4'd0, 8'h01);
        push(1'b0, 1'b0, 8'd1);
        // LD even, len 12 -> full width, 0x03 -> 0
        do_ld(PAR_EVEN, 4'd12, 8'h03);
        push(1'b0, 1'b0, 8'd1);

        // Mark, received 1 -> no error
        start_frame(PAR_MARK, 4'd3, 1'b1);
        send_bits(16'h0000, 3);
        send_bits(16'h0001, 1);
        push(1'b1, 1'b0, 8'd1);
        // Space, received 1 -> error
        start_frame(PAR_SPACE, 4'd2, 1'b1);
        send_bits(16'h0001, 2);
        send_bits(16'h0001, 1);
        push(1'b0, 1'b1, 8'd2);

        // Restart after 3 bits: only the 8 bits after the second START count
        start_frame(PAR_EVEN, 4'd8, 1'b0);
        send_bits(16'h0007, 3);
        start_frame(PAR_EVEN, 4'd8, 1'b0);
        send_bits(16'h0001, 8);
        push(1'b1, 1'b0, 8'd2);

        // START with LD in the same cycle: LD ignored
        bus.LD = 1'b1; bus.P_DATA = 8'hFF;
        start_frame(PAR_EVEN, 4'd2, 1'b0);
        bus.LD = 1'b0;
        send_bits(16'h0001, 2);
        push(1'b1, 1'b0, 8'd2);

        // BIT_VALID in IDLE and alongside START ignored; LD while busy ignored
        send_bits(16'h0001, 1);
        bus.BIT_VALID = 1'b1; bus.BIT_IN = 1'b1;
        start_frame(PAR_EVEN, 4'd2, 1'b0);
        bus.BIT_VALID = 1'b0; bus.BIT_IN = 1'b0;
        do_ld(PAR_EVEN, 4'd8, 8'h01);
        send_bits(16'h0000, 2);
        push(1'b0, 1'b0, 8'd2);

        // PAR_EN dropped mid-frame: IDLE, no result, par_bit forced 0
        do_ld(PAR_EVEN, 4'd1, 8'h01);
        push(1'b1, 1'b0, 8'd2);
        start_frame(PAR_EVEN, 4'd8, 1'b0);
        send_bits(16'h0003, 2);
        bus.PAR_EN = 1'b0;
        tick();
        check("paren_busy",    32'(bus.BUSY),    32'd0);
        check("paren_par_bit", 32'(bus.par_bit), 32'd0);
        bus.PAR_EN = 1'b1;
        tick();

        // Saturation: clear, then 260 single-bit space frames with parity 1
        bus.CLR_CNT = 1'b1;
        tick();
        bus.CLR_CNT = 1'b0;
        check("clr_cnt", 32'(bus.err_cnt), 32'd0);
        for (int i = 0; i < 260; i++) begin
            start_frame(PAR_SPACE, 4'd1, 1'b1);
            send_bits(16'h0000, 1);
            send_bits(16'h0001, 1);
            push(1'b0, 1'b1, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
        end
        tick();
        check("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

        // Async reset mid-frame (4 bits into an 8-bit frame)
        do_ld(PAR_EVEN, 4'd1, 8'h01);
        push(1'b1, 1'b0, 8'd255);
        start_frame(PAR_EVEN, 4'd8, 1'b0);
        send_bits(16'h000F, 4);
        #1 RST = 1'b0;
        #1;
        check("rstmid_busy",    32'(bus.BUSY),    32'd0);
        check("rstmid_par_bit", 32'(bus.par_bit), 32'd0);
        check("rstmid_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rstmid_valid",   32'(bus.par_valid), 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // CLR_CNT coincident with a parity error gives 0
        start_frame(PAR_ODD, 4'd1, 1'b1);
        send_bits(16'h0000, 1);
        send_bits(16'h0000, 1);
        push(1'b1, 1'b1, 8'd1);
        start_frame(PAR_ODD, 4'd1, 1'b1);
        send_bits(16'h0000, 1);
        bus.CLR_CNT = 1'b1;
        send_bits(16'h0000, 1);
        bus.CLR_CNT = 1'b0;
        push(1'b1, 1'b1, 8'd0);
        tick();
        check("clr_with_err", 32'(bus.err_cnt), 32'd0);

        tick(); tick();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Registered, parametrised parity engine for the UART datapath. It generates parity for the TX serializer and checks received parity for the RX deserializer. Data can arrive either bit-serially, one bit per strobe as it is shifted, or as a single parallel word. It supports a runtime frame length of 1..DATA_WIDTH bits, four parity modes, and a saturating parity-error counter.

## Interface
Parameters:
- DATA_WIDTH, 8: maximum data bits per frame; legal 1..16.
- ERR_CNT_WIDTH, 8: width of the parity-error counter.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- PAR_EN  in  1  parity enable; 0 = engine ignores START/LD, par_bit forced 0.
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (1), 11 space (0).
- DATA_LEN  in  $clog2(DATA_WIDTH+1)  data bits per frame.
- CHK_EN  in  1  1 = RX check frame (expects a parity bit after the data); 0 = TX generate.
- START  in  1  one-cycle pulse; begins a serial frame.
- BIT_VALID  in  1  qualifies BIT_IN.
- BIT_IN  in  1  serial data bit, or received parity bit in PAR state.
- LD  in  1  one-cycle pulse; parallel compute on P_DATA.
- P_DATA  in  DATA_WIDTH  parallel word; bit 0 is the first data bit.
- CLR_CNT  in  1  synchronous clear of err_cnt.
- BUSY  out  1  state != IDLE.
- par_bit  out  1  registered parity result.
- par_valid  out  1  one-cycle pulse when par_bit (and par_err) update.
- par_err  out  1  one-cycle pulse; received parity mismatch.
- err_cnt  out  ERR_CNT_WIDTH  saturating mismatch count.

## Operation
- States: IDLE, DATA, PAR.
- START latches PAR_MODE, DATA_LEN and CHK_EN, then goes IDLE→DATA.
  - Acts in any state when PAR_EN=1, so START in DATA/PAR aborts the frame and restarts.
  - Clears the accumulator and the bit counter.
- In DATA, each BIT_VALID does acc ^= BIT_IN and cnt++.
  - On the bit where cnt+1 == latched length: if CHK_EN=0, load par_bit, pulse par_valid, go to IDLE; if CHK_EN=1, go to PAR.
- In PAR, the next BIT_VALID samples BIT_IN as the received parity.
  - Loads par_bit with the expected value and pulses par_valid.
  - Pulses par_err if BIT_IN != expected; goes to IDLE.
- Expected parity:
  - even = acc; odd = ~acc.
  - mark = 1 and space = 0, regardless of data; bits are still counted.
- LD (IDLE only, PAR_EN=1) computes parity over P_DATA[DATA_LEN-1:0]; higher bits are masked. It loads par_bit and pulses par_valid; no check, no state change.
- Length rule: DATA_LEN = 0 or > DATA_WIDTH is treated as DATA_WIDTH.
- err_cnt increments on each par_err and saturates at all-ones.
  - CLR_CNT clears it; CLR_CNT in the same cycle as par_err gives 0.
- Simultaneous events and ignored inputs:
  - START and LD in the same cycle: START wins, LD ignored.
  - LD while BUSY: ignored.
  - BIT_VALID in IDLE: ignored.
  - BIT_VALID in the same cycle as START: ignored (the frame starts empty).
- PAR_EN deasserted mid-frame: return to IDLE next cycle with no par_valid, and par_bit forced to 0.
- Reset values: state IDLE; par_bit, par_valid, par_err, BUSY 0; err_cnt 0; accumulator, counter and latched config 0.

## Timing
- Serial frame: par_valid is high the cycle after the last data bit's BIT_VALID edge (TX), or after the parity bit's BIT_VALID edge (RX check).
- Parallel: par_valid is high the cycle after LD; latency 1.
- par_bit holds its value until the next par_valid or reset.
- par_err is coincident with par_valid.
- err_cnt updates in the same cycle that par_err is visible.
- BUSY rises the cycle after START and falls in the same cycle as the final par_valid.
- BIT_VALID may be asserted on back-to-back cycles; there is no minimum spacing.

## Structure
- Shared uart_pkg holds:
  - PAR_MODE encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - the state enum (IDLE, DATA, PAR);
  - a masked-XOR function used by the LD path.
- Single module; no sub-module needed. The FSM, counter, accumulator and error counter live in one file.

## Test plan
- Serial TX, even, DATA_LEN=8, bits 1,0,1,1,0,0,0,0 (three 1s) → par_valid one cycle after the 8th bit, par_bit=1, par_err=0.
- RX check, odd, DATA_LEN=7, data 0x55 LSB-first (four 1s), received parity 0 → par_bit=1, par_err pulse, err_cnt 0→1.
- LD, even, DATA_LEN=5, P_DATA=0xFF (masked to 0x1F, five 1s) → next cycle par_valid=1, par_bit=1.
- Mark and space modes with CHK_EN=1:
  - mark, received 1 → no error;
  - space, received 1 → par_err, counter increments;
  - drive 255 errors at ERR_CNT_WIDTH=8 → err_cnt stays 255.
- START re-issued after 3 bits of a DATA_LEN=8 frame → accumulator restarts, par_valid only after 8 further bits.
- Assert RST mid-frame (DATA, cnt=4) → outputs 0 immediately, BUSY=0; CLR_CNT coincident with par_err → err_cnt=0.
